// File: rtl/md5_apb_core.sv
// rtl/md5_apb_core.sv - MD5 single-block compression engine behind an APB register window
// Message and digest words can be byte-lane swapped at the bus so software sees MD5 byte order.
module md5_apb_core #(
  parameter int STEPS_PER_CYCLE = 1,
  parameter int MSG_SWAP        = 1,
  parameter int DIGEST_SWAP     = 1
) (
  input  logic        PCLK_IN,
  input  logic        PRESET_IN,
  input  logic        PSEL_IN,
  input  logic        PENABLE_IN,
  input  logic        PWRITE_IN,
  input  logic [4:0]  PADDR_IN,
  input  logic [31:0] PWDATA_IN,
  output logic [31:0] PRDATA_OUT,
  output logic        PREADY_OUT,
  output logic        PSLVERR_OUT,
  output logic        IRQ_OUT
);
  typedef enum logic [1:0] {IDLE, RUN, FINAL} state_t;

  localparam logic [127:0] IV = {32'h67452301, 32'hefcdab89, 32'h98badcfe, 32'h10325476};
  localparam logic [5:0] LAST_STEP = 6'(64 - STEPS_PER_CYCLE);
  localparam logic [5:0] STEP_INC  = 6'(STEPS_PER_CYCLE);

  localparam logic [31:0] K [64] = '{
    32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee, 32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
    32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be, 32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
    32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa, 32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
    32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed, 32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
    32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c, 32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
    32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05, 32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
    32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039, 32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
    32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1, 32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
  };

  // Rotate amount depends only on the round and the step position within a group of four.
  localparam logic [4:0] SHIFT [16] = '{
    5'd7, 5'd12, 5'd17, 5'd22, 5'd5, 5'd9,  5'd14, 5'd20,
    5'd4, 5'd11, 5'd16, 5'd23, 5'd6, 5'd10, 5'd15, 5'd21
  };

  function automatic logic [31:0] bswap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  function automatic logic [127:0] md5_step(input logic [5:0] i, input logic [127:0] st,
                                            input logic [15:0][31:0] x);
    logic [31:0] a, b, c, d, f, t;
    logic [3:0]  g;
    logic [63:0] r;
    {a, b, c, d} = st;
    case (i[5:4])
      2'd0:    begin f = (b & c) | (~b & d); g = i[3:0]; end
      2'd1:    begin f = (d & b) | (~d & c); g = i[3:0] * 4'd5 + 4'd1; end
      2'd2:    begin f = b ^ c ^ d;          g = i[3:0] * 4'd3 + 4'd5; end
      default: begin f = c ^ (b | ~d);       g = i[3:0] * 4'd7; end
    endcase
    t = a + f + K[i] + x[g];
    r = {t, t} << SHIFT[{i[5:4], i[1:0]}];
    return {d, b + r[63:32], b, c};
  endfunction

  state_t           state_q, state_d;
  logic [5:0]       step_q, step_d;
  logic [31:0]      m_q [16];
  logic [31:0]      m_d [16];
  logic [3:0][31:0] dig_q, dig_d;
  logic [127:0]     work_q, work_d;
  logic             init_q, init_d, ie_q, ie_d, done_q, done_d;
  logic [31:0]      blkcnt_q, blkcnt_d;

  logic [15:0][31:0] msg;
  logic [127:0]      round;
  logic [31:0]       rdata;
  logic              busy, acc, unmapped, err, wr_ok;

  assign busy     = state_q != IDLE;
  assign acc      = PSEL_IN & PENABLE_IN;
  assign unmapped = PADDR_IN > 5'h16;
  assign err      = acc & (unmapped | (PWRITE_IN & busy & (~PADDR_IN[4] | (PADDR_IN == 5'h14))));
  assign wr_ok    = acc & PWRITE_IN & ~err;

  always_comb begin
    for (int k = 0; k < 16; k++) msg[k] = (MSG_SWAP != 0) ? bswap(m_q[k]) : m_q[k];
  end

  always_comb begin
    round = work_q;
    for (int k = 0; k < STEPS_PER_CYCLE; k++) round = md5_step(step_q + 6'(k), round, msg);
  end

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    m_d      = m_q;
    dig_d    = dig_q;
    work_d   = work_q;
    init_d   = init_q;
    ie_d     = ie_q;
    done_d   = done_q;
    blkcnt_d = blkcnt_q;
    if (wr_ok && !PADDR_IN[4]) m_d[PADDR_IN[3:0]] = PWDATA_IN;
    if (wr_ok && PADDR_IN == 5'h14) begin
      init_d = PWDATA_IN[1];
      ie_d   = PWDATA_IN[2];
    end
    if (wr_ok && PADDR_IN == 5'h15 && PWDATA_IN[1]) done_d = 1'b0;
    // The FSM assigns after the W1C so a DONE set in FINAL overrides a same-edge clear.
    case (state_q)
      IDLE: begin
        if (wr_ok && PADDR_IN == 5'h14 && PWDATA_IN[0]) begin
          state_d = RUN;
          step_d  = '0;
          done_d  = 1'b0;
          if (PWDATA_IN[1]) begin
            work_d   = IV;
            blkcnt_d = '0;
            for (int k = 0; k < 4; k++) dig_d[k] = IV[127-32*k -: 32];
          end else begin
            work_d = {dig_q[0], dig_q[1], dig_q[2], dig_q[3]};
          end
        end
      end
      RUN: begin
        work_d = round;
        step_d = step_q + STEP_INC;
        if (step_q == LAST_STEP) state_d = FINAL;
      end
      FINAL: begin
        for (int k = 0; k < 4; k++) dig_d[k] = dig_q[k] + work_q[127-32*k -: 32];
        blkcnt_d = blkcnt_q + 32'd1;
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK_IN or posedge PRESET_IN) begin
    if (PRESET_IN) begin
      state_q  <= IDLE;
      step_q   <= '0;
      for (int k = 0; k < 16; k++) m_q[k] <= '0;
      for (int k = 0; k < 4; k++) dig_q[k] <= IV[127-32*k -: 32];
      work_q   <= '0;
      init_q   <= 1'b0;
      ie_q     <= 1'b0;
      done_q   <= 1'b0;
      blkcnt_q <= '0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      m_q      <= m_d;
      dig_q    <= dig_d;
      work_q   <= work_d;
      init_q   <= init_d;
      ie_q     <= ie_d;
      done_q   <= done_d;
      blkcnt_q <= blkcnt_d;
    end
  end

  always_comb begin
    rdata = '0;
    if (PSEL_IN && !PWRITE_IN && !PRESET_IN) begin
      if (!PADDR_IN[4]) begin
        rdata = m_q[PADDR_IN[3:0]];
      end else begin
        case (PADDR_IN[3:0])
          4'h0, 4'h1, 4'h2, 4'h3:
            rdata = (DIGEST_SWAP != 0) ? bswap(dig_q[PADDR_IN[1:0]]) : dig_q[PADDR_IN[1:0]];
          4'h4:    rdata = {29'd0, ie_q, init_q, 1'b0};
          4'h5:    rdata = {30'd0, done_q, busy};
          4'h6:    rdata = blkcnt_q;
          default: rdata = '0;
        endcase
      end
    end
  end

  assign PRDATA_OUT  = rdata;
  assign PREADY_OUT  = acc;
  assign PSLVERR_OUT = err & ~PRESET_IN;
  assign IRQ_OUT     = done_q & ie_q & ~PRESET_IN;
endmodule
